btn_irq_controller: RTL and testbench

//  Interrupt controller between the 4-button debouncer (up/down/left/right event levels) and the CPU.

---
 rtl/btn_irq_controller_if.sv | 22 ++
 rtl/btn_irq_controller.sv | 158 +++++++++++++++
 tb/tb_btn_irq_controller.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_irq_controller_if.sv
// CPU-side bus of the button interrupt controller: register port plus irq/ack handshake.
// The controller connects through the slave modport, the CPU (or bench) through master.
interface btn_irq_controller_if;
  logic       cfg_we;
  logic       cfg_re;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       irq;
  logic [2:0] irq_id;
  logic       irq_ack;

  modport master (
    output cfg_we, cfg_re, cfg_addr, cfg_wdata, irq_ack,
    input  cfg_rdata, irq, irq_id
  );

  modport slave (
    input  cfg_we, cfg_re, cfg_addr, cfg_wdata, irq_ack,
    output cfg_rdata, irq, irq_id
  );
endinterface

// File: rtl/btn_irq_controller.sv
// Button event interrupt controller: edge detect, pending/overflow latches, masked
// arbitration (fixed or round-robin), one-at-a-time irq with ack, saturating press counters.
module btn_irq_controller #(
  parameter int N_BTN  = 4,
  parameter int CNT_W  = 8,
  parameter int ARB_RR = 1
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic [N_BTN-1:0]    btn_evt,
  btn_irq_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, GAP = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [N_BTN-1:0] btn_evt_q, evt_edge, mask, pending, overflow;
  logic [N_BTN-1:0] wr_val, pend_w1c, ovf_w1c, ack_clr, clr, id_onehot, req;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [2:0]       rr_ptr, ptr_nxt, irq_id_q, id_nxt, win_id, arb_start;
  logic             irq_q, irq_nxt, win_vld, cur_ok, mask_we;
  logic [7:0]       rd_val, rdata_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] pad_vec(input logic [N_BTN-1:0] v);
    logic [N_BTN+7:0] t;
    t = {8'd0, v};
    return t[7:0];
  endfunction

  function automatic logic [7:0] pad_cnt(input logic [CNT_W-1:0] v);
    logic [CNT_W+7:0] t;
    t = {8'd0, v};
    return t[7:0];
  endfunction

  // Returns {found, id}: first requesting channel at or after start, wrapping.
  function automatic logic [3:0] arbitrate(input logic [N_BTN-1:0] r,
                                           input logic [2:0] start);
    logic [3:0] res;
    int         idx;
    res = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % N_BTN;
      if (r[idx]) res = {1'b1, 3'(idx)};
    end
    return res;
  endfunction

  assign evt_edge  = btn_evt & ~btn_evt_q;
  assign wr_val    = N_BTN'(bus.cfg_wdata);
  assign mask_we   = bus.cfg_we && (bus.cfg_addr == 3'd0);
  assign pend_w1c  = (bus.cfg_we && bus.cfg_addr == 3'd1) ? wr_val : '0;
  assign ovf_w1c   = (bus.cfg_we && bus.cfg_addr == 3'd2) ? wr_val : '0;
  assign clr       = pend_w1c | ack_clr;
  assign req       = pending & mask;
  assign arb_start = (ARB_RR != 0) ? rr_ptr : 3'd0;
  assign {win_vld, win_id} = arbitrate(req, arb_start);
  assign id_onehot = N_BTN'(1) << irq_id_q;
  assign cur_ok    = |(req & id_onehot);

  // FSM state and irq output registers
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      irq_q    <= 1'b0;
      irq_id_q <= 3'd0;
      rr_ptr   <= 3'd0;
    end else begin
      state    <= state_nxt;
      irq_q    <= irq_nxt;
      irq_id_q <= id_nxt;
      rr_ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    irq_nxt   = 1'b0;
    id_nxt    = 3'd0;
    ack_clr   = '0;
    ptr_nxt   = rr_ptr;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = ASSERT;
          irq_nxt   = 1'b1;
          id_nxt    = win_id;
        end
      end
      ASSERT: begin
        if (bus.irq_ack) begin
          state_nxt = GAP;
          ack_clr   = id_onehot;
          ptr_nxt   = (irq_id_q == 3'(N_BTN - 1)) ? 3'd0 : irq_id_q + 3'd1;
        end else if (!cur_ok) begin
          // CPU masked or cleared the channel before acking: withdraw quietly.
          state_nxt = IDLE;
        end else begin
          irq_nxt = 1'b1;
          id_nxt  = irq_id_q;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Edge history, mask, pending/overflow latches and press counters
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      btn_evt_q <= '1;
      mask      <= '0;
      pending   <= '0;
      overflow  <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      btn_evt_q <= btn_evt;
      if (mask_we) mask <= wr_val;
      // A new edge beats any clear of the same channel and then is not a lost event.
      pending   <= (pending & ~clr) | evt_edge;
      overflow  <= (overflow & ~ovf_w1c) | (evt_edge & pending & ~clr);
      for (int i = 0; i < N_BTN; i++) begin
        if (bus.cfg_we && bus.cfg_addr[2] && int'(bus.cfg_addr[1:0]) == i)
          cnt[i] <= '0;
        else if (evt_edge[i])
          cnt[i] <= sat_inc(cnt[i]);
      end
    end
  end

  always_comb begin
    rd_val = 8'd0;
    case (bus.cfg_addr)
      3'd0: rd_val = pad_vec(mask);
      3'd1: rd_val = pad_vec(pending);
      3'd2: rd_val = pad_vec(overflow);
      3'd3: rd_val = {irq_q, 4'b0000, irq_id_q};
      default: begin
        if (int'(bus.cfg_addr[1:0]) < N_BTN) rd_val = pad_cnt(cnt[bus.cfg_addr[1:0]]);
      end
    endcase
  end

  // Read data register: loaded on a read strobe, held otherwise
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst)             rdata_q <= 8'd0;
    else if (bus.cfg_re) rdata_q <= rd_val;
  end

  assign bus.cfg_rdata = rdata_q;
  assign bus.irq       = irq_q;
  assign bus.irq_id    = irq_id_q;

endmodule

// File: tb/tb_btn_irq_controller.sv
// Bench for btn_irq_controller: directed scenarios plus a random phase, all compared
// against a behavioural model of the controller's rules.
module tb_btn_irq_controller;
  localparam int N_BTN  = 4;
  localparam int CNT_W  = 8;
  localparam int ARB_RR = 1;
  localparam int ALL    = (1 << N_BTN) - 1;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             sysclk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] btn_evt;
  int               n_chk = 0;
  int               n_err = 0;

  btn_irq_controller_if bus ();

  btn_irq_controller #(.N_BTN(N_BTN), .CNT_W(CNT_W), .ARB_RR(ARB_RR)) dut (
    .sysclk  (sysclk),
    .rst     (rst),
    .btn_evt (btn_evt),
    .bus     (bus.slave)
  );

  always #10 sysclk = ~sysclk;

  // Reference state: plain integers and bit sets.
  int m_mask, m_pend, m_ovf, m_hist, m_rdata, m_cur, m_ptr;
  int m_cnt [N_BTN];
  bit m_on, m_gap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mask = 0; m_pend = 0; m_ovf = 0; m_rdata = 0;
    m_cur = 0; m_ptr = 0; m_on = 0; m_gap = 0;
    m_hist = ALL;
    for (int i = 0; i < N_BTN; i++) m_cnt[i] = 0;
  endtask

  function automatic int pick(input int r, input int start);
    for (int k = 0; k < N_BTN; k++) begin
      if (((r >> ((start + k) % N_BTN)) & 1) != 0) return (start + k) % N_BTN;
    end
    return -1;
  endfunction

  function automatic int read_model(input int a);
    case (a)
      0: return m_mask;
      1: return m_pend;
      2: return m_ovf;
      3: return m_on ? (128 + m_cur) : 0;
      default: return (a - 4 < N_BTN) ? m_cnt[a - 4] : 0;
    endcase
  endfunction

  task automatic model_step();
    int e, clr, n_pend, n_ovf, n_mask, wd, a, w;
    bit we, re, ack;
    if (rst) begin
      model_reset();
      return;
    end
    we = bus.cfg_we; re = bus.cfg_re; ack = bus.irq_ack;
    a  = int'(bus.cfg_addr); wd = int'(bus.cfg_wdata);
    e  = int'(btn_evt) & ~m_hist & ALL;
    m_hist = int'(btn_evt);
    if (re) m_rdata = read_model(a);
    clr = (we && a == 1) ? (wd & ALL) : 0;
    if (m_on && ack) clr = clr | (1 << m_cur);
    n_pend = (m_pend & ~clr) | e;
    n_ovf  = (m_ovf & ~((we && a == 2) ? wd : 0) & ALL) | (e & m_pend & ~clr);
    n_mask = (we && a == 0) ? (wd & ALL) : m_mask;
    for (int i = 0; i < N_BTN; i++) begin
      if (we && a == 4 + i) m_cnt[i] = 0;
      else if (((e >> i) & 1) != 0 && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
    end
    if (m_on) begin
      if (ack) begin
        m_on = 0; m_gap = 1; m_ptr = (m_cur + 1) % N_BTN;
      end else if ((((m_pend & m_mask) >> m_cur) & 1) == 0) begin
        m_on = 0;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      w = pick(m_pend & m_mask, (ARB_RR != 0) ? m_ptr : 0);
      if (w >= 0) begin
        m_on = 1; m_cur = w;
      end
    end
    m_pend = n_pend; m_ovf = n_ovf; m_mask = n_mask;
  endtask

  task automatic tick();
    @(posedge sysclk);
    model_step();
    @(negedge sysclk);
    check("irq", bus.irq, m_on);
    check("irq_id", bus.irq_id, m_on ? m_cur : 0);
    check("rdata", bus.cfg_rdata, m_rdata);
  endtask

  task automatic wr(input int a, input int d);
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'(a); bus.cfg_wdata = 8'(d);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input int a, input int exp);
    bus.cfg_re = 1'b1; bus.cfg_addr = 3'(a);
    tick();
    bus.cfg_re = 1'b0;
    check(tag, bus.cfg_rdata, exp);
  endtask

  task automatic press(input int bits);
    btn_evt = btn_evt | N_BTN'(bits);
    tick();
    btn_evt = btn_evt & ~N_BTN'(bits);
    tick();
  endtask

  task automatic wait_irq(input string tag);
    int k = 0;
    while (!bus.irq && k < 10) begin
      tick();
      k++;
    end
    check(tag, bus.irq, 1);
  endtask

  task automatic do_ack();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.cfg_we = 0; bus.cfg_re = 0; bus.cfg_addr = 0; bus.cfg_wdata = 0;
    bus.irq_ack = 0; btn_evt = '0;
    do_reset();
    check("rst_irq", bus.irq, 0);
    check("rst_rdata", bus.cfg_rdata, 0);

    // Single press on channel 2 and its latency
    wr(0, 'h0F);
    btn_evt[2] = 1'b1;
    tick();
    check("t1_lat1", bus.irq, 0);
    tick();
    check("t1_irq", bus.irq, 1);
    check("t1_id", bus.irq_id, 2);
    repeat (3) tick();
    btn_evt[2] = 1'b0;
    rd_expect("t1_pend", 1, 'h04);
    rd_expect("t1_cnt2", 6, 1);

    // Ack, then a one-cycle gap with irq low
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    check("t2_irq_off", bus.irq, 0);
    tick();
    check("t2_gap", bus.irq, 0);
    rd_expect("t2_pend", 1, 0);

    // Round-robin ordering
    do_reset();
    wr(0, 'h0F);
    press('b1001);
    wait_irq("t3a_irq");
    check("t3a_id", bus.irq_id, 0);
    do_ack();
    wait_irq("t3b_irq");
    check("t3b_id", bus.irq_id, 3);
    do_ack();
    press('b0001);
    wait_irq("t3c_irq");
    do_ack();
    press('b1001);
    wait_irq("t3d_irq");
    check("t3d_id", bus.irq_id, 3);
    do_ack();
    wait_irq("t3e_irq");
    check("t3e_id", bus.irq_id, 0);
    do_ack();

    // Lost event on channel 1
    press('b0010);
    press('b0010);
    rd_expect("t4_ovf", 2, 'h02);
    rd_expect("t4_cnt1", 5, 2);
    wr(2, 'h02);
    rd_expect("t4_ovf_clr", 2, 0);
    wait_irq("t4_irq");
    do_ack();

    // Masked event, late enable, retraction by W1C
    wr(0, 'h00);
    press('b0001);
    rd_expect("t5_pend", 1, 'h01);
    check("t5_masked", bus.irq, 0);
    wr(0, 'h01);
    wait_irq("t5_irq");
    check("t5_id", bus.irq_id, 0);
    wr(1, 'h01);
    tick();
    check("t5_retract", bus.irq, 0);
    rd_expect("t5_pend_clr", 1, 0);

    // Counter saturation, then reset in the middle of an interrupt
    wr(0, 'h08);
    repeat (256) press('b1000);
    rd_expect("t6_sat", 7, 255);
    check("t6_irq", bus.irq, 1);
    check("t6_id", bus.irq_id, 3);
    #3 rst = 1'b1;
    model_reset();
    #1;
    check("t6_rst_irq", bus.irq, 0);
    check("t6_rst_id", bus.irq_id, 0);
    check("t6_rst_rdata", bus.cfg_rdata, 0);
    tick();
    rst = 1'b0;
    for (int a = 0; a < 8; a++) rd_expect($sformatf("t6_reg%0d", a), a, 0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < N_BTN; b++)
        if ($urandom_range(7) == 0) btn_evt[b] = ~btn_evt[b];
      bus.cfg_we    = ($urandom_range(5) == 0);
      bus.cfg_re    = ($urandom_range(2) == 0);
      bus.cfg_addr  = 3'($urandom_range(7));
      bus.cfg_wdata = 8'($urandom);
      bus.irq_ack   = bus.irq ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
      tick();
    end
    bus.cfg_we = 0; bus.cfg_re = 0; bus.irq_ack = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
